// File: rtl/sm_sync.sv
// Multi-stage synchronizer for a single asynchronous input.
// The output comes up at RESET_VAL so an idle-high line reads as idle straight out of reset.
module sm_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sm_als_slave.sv
// Read-only SPI responder modelling the PmodALS / ADC081S021 light sensor.
// The frame word is latched when CS falls and is shifted out MSB first, one bit per SCK
// falling edge, so the master captures it just before each SCK rising edge.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no frame; sdo and sdo_oe low; SCK ignored
// ST_ACTIVE | frame in progress; sdo_oe high; shift on each SCK fall
module sm_als_slave #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             sck,
  output logic             sdo,
  output logic             sdo_oe,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             frame_done,
  output logic             frame_abort
);

  localparam int               CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  logic cs_s;
  logic sck_s;
  logic cs_prev_q;
  logic sck_prev_q;
  logic cs_fall;
  logic cs_rise;
  logic sck_fall;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] shift_q,  shift_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             sdo_q,    sdo_d;
  logic             done_q,   done_d;
  logic             abort_q,  abort_d;

  sm_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs),
    .q_o   (cs_s)
  );

  sm_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sck),
    .q_o   (sck_s)
  );

  // Previous synchronized levels for edge detection; idle-high at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q  <= 1'b1;
      sck_prev_q <= 1'b1;
    end else begin
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  assign cs_fall  =  cs_prev_q  & ~cs_s;
  assign cs_rise  = ~cs_prev_q  &  cs_s;
  assign sck_fall =  sck_prev_q & ~sck_s;

  // FSM, shift register, bit counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic; cs_rise takes priority over a coincident sck_fall.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (cs_fall) begin
          shift_d = data;
          cnt_d   = '0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
          sdo_d   = 1'b0;
          if (cnt_q == CNT_MAX) begin
            done_d = 1'b1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (sck_fall) begin
          // Zeros fill from the LSB, so bits beyond WIDTH read as 0.
          sdo_d   = shift_q[WIDTH-1];
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sdo_d   = 1'b0;
      end
    endcase
  end

  assign sdo         = sdo_q;
  assign sdo_oe      = (state_q == ST_ACTIVE);
  assign busy        = (state_q == ST_ACTIVE);
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_sm_als_slave.sv
// Bench for sm_als_slave: a task-driven SPI master with SCK phases of 8 clk cycles,
// run against a SYNC_STAGES=2 and a SYNC_STAGES=3 instance sharing the same pins.
module tb_sm_als_slave;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cs = 1'b1;
  logic         sck = 1'b1;
  logic [W-1:0] data = '0;

  logic sdo2, oe2, busy2, done2, abort2;
  logic sdo3, oe3, busy3, done3, abort3;

  int total = 0;
  int bad = 0;
  int done2_cnt = 0, abort2_cnt = 0, done3_cnt = 0, abort3_cnt = 0;

  logic exp_q[$];

  typedef struct {
    logic [W-1:0] word;
    int           nbits;
    logic [W-1:0] exp_word;
    int           exp_done;
    int           exp_abort;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  sm_als_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .sck         (sck),
    .sdo         (sdo2),
    .sdo_oe      (oe2),
    .data        (data),
    .busy        (busy2),
    .frame_done  (done2),
    .frame_abort (abort2)
  );

  sm_als_slave #(.WIDTH(W), .SYNC_STAGES(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs          (cs),
    .sck         (sck),
    .sdo         (sdo3),
    .sdo_oe      (oe3),
    .data        (data),
    .busy        (busy3),
    .frame_done  (done3),
    .frame_abort (abort3)
  );

  // Count cycles each pulse is high; a one-cycle pulse adds exactly 1.
  always @(negedge clk) begin
    if (done2)  done2_cnt++;
    if (abort2) abort2_cnt++;
    if (done3)  done3_cnt++;
    if (abort3) abort3_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " sdo2"}, {31'd0, sdo2}, 32'd0);
    check({name, " oe2"},  {31'd0, oe2},  32'd0);
    check({name, " busy2"}, {31'd0, busy2}, 32'd0);
    check({name, " sdo3"}, {31'd0, sdo3}, 32'd0);
    check({name, " oe3"},  {31'd0, oe3},  32'd0);
  endtask

  // One full master transaction; optionally changes data after the frame has started.
  task automatic run_frame(input logic [W-1:0] w, input int n, input bit chg,
                           input logic [W-1:0] w2, output logic [W-1:0] mword);
    logic e;
    @(negedge clk);
    data = w;
    cs = 1'b0;
    repeat (6) @(negedge clk);
    if (chg) data = w2;
    repeat (2) @(negedge clk);
    check("start oe2", {31'd0, oe2}, 32'd1);
    check("start busy3", {31'd0, busy3}, 32'd1);
    check("start sdo2", {31'd0, sdo2}, 32'd0);
    mword = '0;
    for (int i = 1; i <= n; i++) begin
      sck = 1'b0;
      exp_q.push_back((i <= W) ? w[W-i] : 1'b0);
      repeat (8) @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("bit%0d sdo2", i), {31'd0, sdo2}, {31'd0, e});
      check($sformatf("bit%0d sdo3", i), {31'd0, sdo3}, {31'd0, e});
      if (i <= W) mword = {mword[W-2:0], sdo2};
      sck = 1'b1;
      repeat (8) @(negedge clk);
    end
    cs = 1'b1;
    repeat (8) @(negedge clk);
    check_idle("end");
  endtask

  task automatic frame_and_check(input string name, input logic [W-1:0] w, input int n,
                                 input bit chg, input logic [W-1:0] w2,
                                 input logic [W-1:0] exp_word, input int ed, input int ea);
    logic [W-1:0] mw;
    int d2, a2, d3, a3;
    d2 = done2_cnt; a2 = abort2_cnt; d3 = done3_cnt; a3 = abort3_cnt;
    run_frame(w, n, chg, w2, mw);
    check({name, " word"}, {16'd0, mw}, {16'd0, exp_word});
    check({name, " done2"}, done2_cnt - d2, ed);
    check({name, " abort2"}, abort2_cnt - a2, ea);
    check({name, " done3"}, done3_cnt - d3, ed);
    check({name, " abort3"}, abort3_cnt - a3, ea);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k2, k3, d2, a2;

    vecs[0] = '{16'h0AB0, 16, 16'h0AB0, 1, 0};
    vecs[1] = '{16'hF000,  5, 16'h001E, 0, 1};
    vecs[2] = '{16'h1234, 16, 16'h1234, 1, 0};
    vecs[3] = '{16'h8001, 20, 16'h8001, 1, 0};
    vecs[4] = '{16'hFFFF, 16, 16'hFFFF, 1, 0};
    vecs[5] = '{16'h0000, 16, 16'h0000, 1, 0};
    vecs[6] = '{16'hA5C3,  1, 16'h0001, 0, 1};
    vecs[7] = '{16'h5A5A, 15, 16'h2D2D, 0, 1};

    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset done", {31'd0, done2}, 32'd0);
    check("reset abort", {31'd0, abort2}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("post reset");

    for (int v = 0; v < 8; v++) begin
      frame_and_check($sformatf("vec%0d", v), vecs[v].word, vecs[v].nbits, 1'b0, '0,
                      vecs[v].exp_word, vecs[v].exp_done, vecs[v].exp_abort);
    end

    // Data changing mid-frame must not affect the current frame; the next frame reloads.
    frame_and_check("chg cur", 16'h0AB0, 16, 1'b1, 16'hFFFF, 16'h0AB0, 1, 0);
    frame_and_check("chg next", 16'hFFFF, 16, 1'b0, '0, 16'hFFFF, 1, 0);

    // Latency from the SCK pin falling to sdo changing, for both synchronizer depths.
    @(negedge clk);
    data = 16'h8000;
    cs = 1'b0;
    repeat (8) @(negedge clk);
    sck = 1'b0;
    k2 = 0; k3 = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      if (k2 == 0 && sdo2) k2 = k;
      if (k3 == 0 && sdo3) k3 = k;
    end
    check("latency s2", k2, 3);
    check("latency s3", k3, 4);
    @(negedge clk);
    sck = 1'b1;
    repeat (8) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);

    // Reset in the middle of a frame: outputs drop at once and no pulse is emitted.
    @(negedge clk);
    data = 16'h7F00;
    cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      sck = 1'b0;
      repeat (8) @(negedge clk);
      sck = 1'b1;
      repeat (8) @(negedge clk);
    end
    check("pre-reset sdo2", {31'd0, sdo2}, 32'd1);
    d2 = done2_cnt; a2 = abort2_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("mid reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst done", done2_cnt - d2, 0);
    check("rst abort", abort2_cnt - a2, 0);
    check("rst sdo2", {31'd0, sdo2}, 32'd0);
    check("rst sdo3", {31'd0, sdo3}, 32'd0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check_idle("after cs release");

    frame_and_check("post rst", 16'hC3A5, 16, 1'b0, '0, 16'hC3A5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
